irq_request_unit: RTL

//  Interrupt-request front end for SM83Core; drives its CPU_IRQ_TRIG input and consumes CPU_IRQ_ACK.

---
 rtl/irq_request_unit_if.sv | 22 ++
 rtl/irq_request_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/irq_request_unit_if.sv
// CPU-side bus of the interrupt-request unit: IF register access plus the
// request/acknowledge pair shared with the SM83 core.
interface irq_request_unit_if;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic        RD;
  logic        WR;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic [7:0]  CPU_IRQ_TRIG;
  logic [7:0]  CPU_IRQ_ACK;

  modport master (
    output A, D_IN, RD, WR, CPU_IRQ_ACK,
    input  D_OUT, D_OE, CPU_IRQ_TRIG
  );

  modport slave (
    input  A, D_IN, RD, WR, CPU_IRQ_ACK,
    output D_OUT, D_OE, CPU_IRQ_TRIG
  );
endinterface

// File: rtl/irq_request_unit.sv
// Interrupt-request front end: edge-detects peripheral requests into IF (0xFF0F),
// debounces the joypad lines and raises WAKE on an accepted press.
module irq_request_unit #(
  parameter logic [15:0] IF_ADDR    = 16'hFF0F,
  parameter int unsigned JOY_FILTER = 4
) (
  input  logic                CLK,
  input  logic                SYNC_RESET,
  input  logic                VBLANK_REQ,
  input  logic                STAT_REQ,
  input  logic                TIMER_REQ,
  input  logic                SERIAL_REQ,
  input  logic [3:0]          nJOY,
  irq_request_unit_if.slave   bus,
  output logic                WAKE
);

  localparam logic [3:0] JOY_LAST = 4'(JOY_FILTER - 1);

  typedef enum logic {
    JOY_IDLE  = 1'b0,
    JOY_COUNT = 1'b1
  } joy_state_t;

  joy_state_t joy_state;
  logic [3:0] joy_stable;
  logic [3:0] joy_prev;
  logic [3:0] joy_cnt;
  logic       joy_accept;

  logic [4:0] if_reg;
  logic [4:0] if_next;
  logic [3:0] src;
  logic [3:0] prev_src;
  logic [4:0] src_edge;
  logic       wr_d;
  logic       wstb;
  logic       read_hit;
  logic [7:0] trig;
  logic       wake_q;
  logic       unused_bits;

  // Request edges and the IF next-state: a fresh edge beats an ack, an ack beats a write.
  always_comb begin
    src         = {SERIAL_REQ, TIMER_REQ, STAT_REQ, VBLANK_REQ};
    joy_accept  = (joy_state == JOY_COUNT) && (nJOY != joy_stable) &&
                  (nJOY == joy_prev) && (joy_cnt == JOY_LAST);
    src_edge    = {joy_accept && ((joy_stable & ~nJOY) != 4'h0), src & ~prev_src};
    wstb        = bus.WR && !wr_d && (bus.A == IF_ADDR);
    if_next     = ((wstb ? bus.D_IN[4:0] : if_reg) & ~bus.CPU_IRQ_ACK[4:0]) | src_edge;
    read_hit    = bus.RD && (bus.A == IF_ADDR);
    unused_bits = ^{bus.D_IN[7:5], bus.CPU_IRQ_ACK[7:5]};
  end

  assign bus.D_OE         = read_hit;
  assign bus.D_OUT        = read_hit ? {3'b111, if_reg} : 8'h00;
  assign bus.CPU_IRQ_TRIG = trig;
  assign WAKE             = wake_q;

  // One shared counter debounces all four joypad lines; any raw change restarts it.
  always_ff @(posedge CLK) begin
    if (SYNC_RESET) begin
      if_reg     <= 5'h00;
      prev_src   <= 4'h0;
      wr_d       <= 1'b0;
      trig       <= 8'h00;
      wake_q     <= 1'b0;
      joy_stable <= 4'hF;
      joy_prev   <= 4'hF;
      joy_cnt    <= 4'h0;
      joy_state  <= JOY_IDLE;
    end else begin
      if_reg   <= if_next;
      prev_src <= src;
      wr_d     <= bus.WR;
      trig     <= {3'b000, if_next};
      wake_q   <= src_edge[4];
      joy_prev <= nJOY;
      case (joy_state)
        JOY_IDLE: begin
          if (nJOY != joy_stable) begin
            joy_state <= JOY_COUNT;
            joy_cnt   <= 4'h0;
          end
        end
        JOY_COUNT: begin
          if (nJOY == joy_stable) begin
            joy_state <= JOY_IDLE;
            joy_cnt   <= 4'h0;
          end else if (nJOY != joy_prev) begin
            joy_cnt <= 4'h0;
          end else if (joy_cnt == JOY_LAST) begin
            joy_stable <= nJOY;
            joy_cnt    <= 4'h0;
            joy_state  <= JOY_IDLE;
          end else begin
            joy_cnt <= joy_cnt + 4'h1;
          end
        end
        default: begin
          joy_state <= JOY_IDLE;
          joy_cnt   <= 4'h0;
        end
      endcase
    end
  end

endmodule
